// File: rtl/feedback_loop_top.sv
// feedback_loop_top
//   Two-stage dataflow loop with a buffered feedback channel.
//   Stage n2 adds the input sample to the token at the head of the feedback
//   FIFO (z = x + y). Stage n3 registers z onto the output and pushes
//   y = z >> SHIFT back into the FIFO. The FIFO starts with DELAY tokens of
//   value INIT, so DELAY samples can be in the loop at once.
//
// Ports
//   clock, reset           clock; asynchronous active-high reset
//   flush                  synchronous reinitialise, dominates every transfer
//   n1_x / _valid / _ready input stream (valid/ready)
//   n4_w / _valid / _ready output stream (registered, valid/ready)
//   fb_count               feedback FIFO occupancy
module feedback_loop_top #(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 4,
  parameter int               DELAY = 1,
  parameter int               SHIFT = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           n1_x,
  input  logic                       n1_x_valid,
  output logic                       n1_x_ready,
  output logic [WIDTH-1:0]           n4_w,
  output logic                       n4_w_valid,
  input  logic                       n4_w_ready,
  output logic [$clog2(DEPTH+1)-1:0] fb_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] WR_INIT  = AW'(DELAY % DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(DELAY);

  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  function automatic logic [WIDTH-1:0] fb_shift(input logic [WIDTH-1:0] a);
    return a >> SHIFT;
  endfunction

  // DEPTH is a power of two, but DEPTH == 1 still needs an explicit wrap to 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [WIDTH-1:0] z_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             move1;
  logic             move2;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign head       = mem[rd_ptr];
  assign move2      = vld_p1 && (!n4_w_valid || n4_w_ready);
  // The head token must already be in the FIFO: a token pushed this cycle is
  // not forwarded, which halves throughput when DELAY == 1.
  assign n1_x_ready = (count != '0) && (!vld_p1 || move2) && !flush;
  assign move1      = n1_x_valid && n1_x_ready;
  assign push       = move2 && !flush;
  assign pop        = move1;
  assign fb_count   = count;

  // ---- stage p1: z = x + head token ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (move1) begin
      vld_p1 <= 1'b1;
    end else if (move2) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (move1) begin
      z_p1 <= wrap_add(n1_x, head);
    end
  end

  // ---- stage p2: output register ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n4_w       <= '0;
      n4_w_valid <= 1'b0;
    end else if (flush) begin
      n4_w_valid <= 1'b0;
    end else if (move2) begin
      n4_w       <= z_p1;
      n4_w_valid <= 1'b1;
    end else if (n4_w_valid && n4_w_ready) begin
      n4_w_valid <= 1'b0;
    end
  end

  // ---- feedback FIFO: y = z >> SHIFT back to stage p1 ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < DELAY) ? INIT : '0;
      end
      rd_ptr <= '0;
      wr_ptr <= WR_INIT;
      count  <= CNT_INIT;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < DELAY) ? INIT : '0;
      end
      rd_ptr <= '0;
      wr_ptr <= WR_INIT;
      count  <= CNT_INIT;
    end else begin
      if (push) begin
        mem[wr_ptr] <= fb_shift(z_p1);
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_feedback_loop_top.sv
module tb_feedback_loop_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush [3];
  logic [15:0] x     [3];
  logic        xv    [3];
  logic        xr    [3];
  logic [15:0] w     [3];
  logic        wv    [3];
  logic        wr    [3];
  logic [2:0]  cnt   [3];

  always #5 clk = ~clk;

  // u0: DELAY=1 INIT=0, u1: DELAY=2 INIT=0, u2: DELAY=1 INIT=1
  feedback_loop_top #(.WIDTH(16), .DEPTH(4), .DELAY(1), .SHIFT(1), .INIT(16'h0000)) u0 (
    .clock(clk), .reset(rst), .flush(flush[0]),
    .n1_x(x[0]), .n1_x_valid(xv[0]), .n1_x_ready(xr[0]),
    .n4_w(w[0]), .n4_w_valid(wv[0]), .n4_w_ready(wr[0]), .fb_count(cnt[0]));

  feedback_loop_top #(.WIDTH(16), .DEPTH(4), .DELAY(2), .SHIFT(1), .INIT(16'h0000)) u1 (
    .clock(clk), .reset(rst), .flush(flush[1]),
    .n1_x(x[1]), .n1_x_valid(xv[1]), .n1_x_ready(xr[1]),
    .n4_w(w[1]), .n4_w_valid(wv[1]), .n4_w_ready(wr[1]), .fb_count(cnt[1]));

  feedback_loop_top #(.WIDTH(16), .DEPTH(4), .DELAY(1), .SHIFT(1), .INIT(16'h0001)) u2 (
    .clock(clk), .reset(rst), .flush(flush[2]),
    .n1_x(x[2]), .n1_x_valid(xv[2]), .n1_x_ready(xr[2]),
    .n4_w(w[2]), .n4_w_valid(wv[2]), .n4_w_ready(wr[2]), .fb_count(cnt[2]));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          d;
    logic        fl;
    logic [15:0] x;
    logic        xv;
    logic        wr;
    logic        e_rdy;
    logic        e_wv;
    logic [15:0] e_w;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];

  function automatic vec_t mk(int d, logic fl, logic [15:0] xi, logic xvi, logic wri,
                              logic e_rdy, logic e_wv, logic [15:0] e_w, logic [2:0] e_cnt);
    vec_t v;
    v.d = d; v.fl = fl; v.x = xi; v.xv = xvi; v.wr = wri;
    v.e_rdy = e_rdy; v.e_wv = e_wv; v.e_w = e_w; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Inputs are applied at the falling edge; outputs checked 1 time unit later,
  // i.e. the state left by the previous rising edge.
  task automatic apply_check(input vec_t v, input int idx);
    flush[v.d] = v.fl;
    x[v.d]     = v.x;
    xv[v.d]    = v.xv;
    wr[v.d]    = v.wr;
    #1;
    chk($sformatf("row%0d_ready", idx), 32'(xr[v.d]),  32'(v.e_rdy));
    chk($sformatf("row%0d_wvalid", idx), 32'(wv[v.d]), 32'(v.e_wv));
    chk($sformatf("row%0d_count", idx), 32'(cnt[v.d]), 32'(v.e_cnt));
    if (v.e_wv) chk($sformatf("row%0d_w", idx), 32'(w[v.d]), 32'(v.e_w));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      apply_check(tv[i], i);
    end
  endtask

  task automatic idle(input int d);
    flush[d] = 1'b0; xv[d] = 1'b0; wr[d] = 1'b1; x[d] = '0;
  endtask

  // Scoreboard and invariant monitor for u1 (and invariant for u0).
  bit          sb_on = 1'b0;
  logic [15:0] q_tok [$];
  logic [15:0] q_exp [$];
  logic [15:0] mz;
  logic [15:0] me;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("inv_u1", 32'(cnt[1]) + 32'(u1.vld_p1), 32'd2);
      chk("inv_u0", 32'(cnt[0]) + 32'(u0.vld_p1), 32'd1);
      chk("pop_empty_u1", 32'(xv[1] && xr[1] && (cnt[1] == 3'd0)), 32'd0);
      chk("push_full_u1", 32'(u1.move2 && (cnt[1] == 3'd4)), 32'd0);
    end
    if (sb_on && !rst && !flush[1]) begin
      if (wv[1] && wr[1]) begin
        if (q_exp.size() == 0) begin
          chk("sb_unexpected_w", 32'(w[1]), 32'hFFFF_FFFF);
        end else begin
          me = q_exp.pop_front();
          chk("sb_w", 32'(w[1]), 32'(me));
        end
      end
      if (xv[1] && xr[1]) begin
        mz = x[1] + q_tok.pop_front();
        q_tok.push_back(mz >> 1);
        q_exp.push_back(mz);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] wheld;

  initial begin
    // u0 (DELAY=1): x=4 stream, then hold output, flush with s1 and output full
    tv[0]  = mk(0, 0, 16'd4, 1, 1, 1, 0, 16'd0, 3'd1);
    tv[1]  = mk(0, 0, 16'd4, 1, 1, 0, 0, 16'd0, 3'd0);
    tv[2]  = mk(0, 0, 16'd4, 1, 1, 1, 1, 16'd4, 3'd1);
    tv[3]  = mk(0, 0, 16'd4, 1, 1, 0, 0, 16'd0, 3'd0);
    tv[4]  = mk(0, 0, 16'd4, 1, 1, 1, 1, 16'd6, 3'd1);
    tv[5]  = mk(0, 0, 16'd4, 1, 1, 0, 0, 16'd0, 3'd0);
    tv[6]  = mk(0, 0, 16'd4, 1, 1, 1, 1, 16'd7, 3'd1);
    tv[7]  = mk(0, 0, 16'd4, 1, 1, 0, 0, 16'd0, 3'd0);
    tv[8]  = mk(0, 0, 16'd4, 1, 0, 1, 1, 16'd7, 3'd1);
    tv[9]  = mk(0, 1, 16'd4, 1, 0, 0, 1, 16'd7, 3'd0);
    tv[10] = mk(0, 0, 16'd4, 1, 1, 1, 0, 16'd0, 3'd1);
    tv[11] = mk(0, 0, 16'd4, 1, 1, 0, 0, 16'd0, 3'd0);
    tv[12] = mk(0, 0, 16'd4, 1, 1, 1, 1, 16'd4, 3'd1);
    tv[13] = mk(0, 0, 16'd4, 1, 1, 0, 0, 16'd0, 3'd0);
    tv[14] = mk(0, 0, 16'd4, 1, 1, 1, 1, 16'd6, 3'd1);
    // u1 (DELAY=2): full rate, w = 4,4,6,6,7,7
    tv[15] = mk(1, 0, 16'd4, 1, 1, 1, 0, 16'd0, 3'd2);
    tv[16] = mk(1, 0, 16'd4, 1, 1, 1, 0, 16'd0, 3'd1);
    tv[17] = mk(1, 0, 16'd4, 1, 1, 1, 1, 16'd4, 3'd1);
    tv[18] = mk(1, 0, 16'd4, 1, 1, 1, 1, 16'd4, 3'd1);
    tv[19] = mk(1, 0, 16'd4, 1, 1, 1, 1, 16'd6, 3'd1);
    tv[20] = mk(1, 0, 16'd4, 1, 1, 1, 1, 16'd6, 3'd1);
    tv[21] = mk(1, 0, 16'd4, 1, 1, 1, 1, 16'd7, 3'd1);
    tv[22] = mk(1, 0, 16'd4, 1, 1, 1, 1, 16'd7, 3'd1);
    // u2 (DELAY=1, INIT=1): wrap-around
    tv[23] = mk(2, 0, 16'hFFFF, 1, 1, 1, 0, 16'h0000, 3'd1);
    tv[24] = mk(2, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 3'd0);
    tv[25] = mk(2, 0, 16'h0001, 1, 1, 1, 1, 16'h0000, 3'd1);
    tv[26] = mk(2, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 3'd0);
    tv[27] = mk(2, 0, 16'h0000, 0, 1, 1, 1, 16'h0001, 3'd1);

    rst = 1'b1;
    for (int d = 0; d < 3; d++) idle(d);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_w_u%0d", d),     32'(w[d]),  32'd0);
      chk($sformatf("reset_wv_u%0d", d),    32'(wv[d]), 32'd0);
      chk($sformatf("reset_ready_u%0d", d), 32'(xr[d]), 32'd1);
      chk($sformatf("reset_cnt_u%0d", d),   32'(cnt[d]), (d == 1) ? 32'd2 : 32'd1);
    end
    rst = 1'b0;

    run_rows(0, 14);
    idle(0);
    run_rows(23, 27);
    idle(2);
    run_rows(15, 22);

    // Asynchronous reset pulse between clock edges, output valid beforehand
    @(posedge clk);
    #1;
    chk("prereset_wv", 32'(wv[1]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_wv",    32'(wv[1]), 32'd0);
    chk("async_w",     32'(w[1]),  32'd0);
    chk("async_cnt",   32'(cnt[1]), 32'd2);
    chk("async_ready", 32'(xr[1]), 32'd1);
    #1 rst = 1'b0;
    run_rows(15, 22);

    // Flush, then a varied stream with a 5-cycle output stall
    @(negedge clk);
    flush[1] = 1'b1; xv[1] = 1'b0; wr[1] = 1'b1;
    @(negedge clk);
    flush[1] = 1'b0;
    q_tok.delete(); q_exp.delete();
    q_tok.push_back(16'd0); q_tok.push_back(16'd0);
    sb_on = 1'b1;
    #1;
    chk("flush_wv",  32'(wv[1]), 32'd0);
    chk("flush_cnt", 32'(cnt[1]), 32'd2);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      x[1]  = 16'(i * 37 + 5);
      xv[1] = (i != 5) && (i != 20);
      wr[1] = !(i >= 10 && i <= 14);
      #1;
      if (i == 10) begin
        wheld = w[1];
        chk("bp_start_wv", 32'(wv[1]), 32'd1);
      end
      if (i >= 11 && i <= 14) begin
        chk($sformatf("bp_hold_w_%0d", i),  32'(w[1]),  32'(wheld));
        chk($sformatf("bp_hold_wv_%0d", i), 32'(wv[1]), 32'd1);
      end
      if (i == 12) chk("bp_ready_low", 32'(xr[1]), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      xv[1] = 1'b0; wr[1] = 1'b1;
    end
    @(negedge clk);
    #3;
    chk("sb_drained", 32'(q_exp.size()), 32'd0);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
